param_step_counter: RTL and testbench

- Parametrised successor to the team's free-running enable counter. Used for iteration, point-index and cluster-index counting in the K-means datapath.
- Adds the following over the plain counter:
  - configurable width and modulo limit
  - up/down direction
  - synchronous clear and parallel load
  - wrap or saturate mode
  - enable prescaler
  - registered terminal-count pulse
- Sits beside the K-means controller FSM, which loads, clears and steps it.

---
 rtl/kmeans_cnt_pkg.sv | 8 +
 rtl/param_step_prescaler.sv | 30 +++
 rtl/param_step_counter.sv | 69 ++++++
 tb/tb_param_step_counter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/kmeans_cnt_pkg.sv
// kmeans_cnt_pkg: shared direction/mode types and width helper for the K-means counters
package kmeans_cnt_pkg;
    typedef enum logic {CNT_DOWN = 1'b0, CNT_UP = 1'b1} cnt_dir_e;
    typedef enum logic {CNT_WRAP = 1'b0, CNT_SAT = 1'b1} cnt_mode_e;
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction
endpackage

// File: rtl/param_step_prescaler.sv
// param_step_prescaler: emits one step per PRESCALE enabled cycles; PRESCALE=1 is a flop-free pass-through
module param_step_prescaler
    import kmeans_cnt_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr_i,
    input  logic enable,
    output logic step_o
);
    generate
        if (PRESCALE == 1) begin : g_bypass
            logic unused_ok;
            assign unused_ok = &{clk, rstn, clr_i};
            assign step_o = enable;
        end else begin : g_div
            localparam int PW = clog2_min1(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
            logic [PW-1:0] cnt;
            // disabled cycles hold the phase rather than restarting it
            always_ff @(posedge clk or posedge rstn)
                if (rstn) cnt <= '0;
                else if (clr_i) cnt <= '0;
                else if (enable) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            assign step_o = enable && (cnt == LAST);
        end
    endgenerate
endmodule

// File: rtl/param_step_counter.sv
// param_step_counter: up/down modulo counter with clear, clamped load, wrap/saturate, prescaler and tc pulse
// Optional ovf_sticky output enabled by PARAM_STEP_COUNTER_OVF_STICKY_EN
module param_step_counter
    import kmeans_cnt_pkg::*;
#(
    parameter int          WIDTH    = 6,
    parameter logic [31:0] MAX_VAL  = 63,
    parameter int          PRESCALE = 1,
    parameter int          SATURATE = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             at_zero,
    output logic             at_max
`ifdef PARAM_STEP_COUNTER_OVF_STICKY_EN
    ,
    output logic             ovf_sticky
`endif
);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
    localparam cnt_mode_e MODE = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;
    cnt_dir_e dir;
    logic step, bstep;
    logic [WIDTH-1:0] nxt;
    param_step_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clk    (clk),
        .rstn   (rstn),
        .clr_i  (clr | load),
        .enable (enable),
        .step_o (step)
    );
    assign dir     = cnt_dir_e'(up_dn);
    assign at_zero = (out == '0);
    assign at_max  = (out == MAXV);
    // boundary is checked before the add, so no WIDTH+1 carry is ever needed
    always_comb begin
        bstep = step && ((dir == CNT_UP) ? at_max : at_zero);
        nxt = (dir == CNT_UP)
            ? (at_max ? ((MODE == CNT_SAT) ? out : '0) : out + 1'b1)
            : (at_zero ? ((MODE == CNT_SAT) ? out : MAXV) : out - 1'b1);
    end
    always_ff @(posedge clk or posedge rstn)
        if (rstn) begin
            out <= '0;
            tc  <= 1'b0;
        end else if (clr) begin
            out <= '0;
            tc  <= 1'b0;
        end else if (load) begin
            out <= (load_val > MAXV) ? MAXV : load_val;
            tc  <= 1'b0;
        end else begin
            out <= step ? nxt : out;
            tc  <= bstep;
        end
`ifdef PARAM_STEP_COUNTER_OVF_STICKY_EN
    always_ff @(posedge clk or posedge rstn)
        if (rstn) ovf_sticky <= 1'b0;
        else if (clr) ovf_sticky <= 1'b0;
        else if (!load && bstep) ovf_sticky <= 1'b1;
`endif
endmodule

// File: tb/tb_param_step_counter.sv
// tb_param_step_counter: five parameter sets driven in lockstep, checked by a queued reference model
module tb_param_step_counter;
    localparam int N = 5;
    localparam int CM[N] = '{63, 9, 9, 63, 63};
    localparam int CP[N] = '{1, 1, 1, 4, 3};
    localparam int CS[N] = '{0, 0, 1, 0, 1};

    typedef struct packed {
        logic [N-1:0][5:0] o;
        logic [N-1:0]      t;
        logic [N-1:0]      v;
    } exp_t;

    logic clk = 1'b0;
    logic rstn, clr, enable, up_dn, load;
    logic [5:0] load_val;
    logic [N-1:0][5:0] out_v;
    logic [N-1:0] tc_v, az_v, am_v;
`ifdef PARAM_STEP_COUNTER_OVF_STICKY_EN
    logic [N-1:0] ovf_v;
`endif

    exp_t q[$];
    int mo[N], mp[N], mv[N];
    int total = 0, passed = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        param_step_counter #(.WIDTH(6), .MAX_VAL(CM[g]), .PRESCALE(CP[g]), .SATURATE(CS[g])) u_dut (
            .clk        (clk),
            .rstn       (rstn),
            .clr        (clr),
            .enable     (enable),
            .up_dn      (up_dn),
            .load       (load),
            .load_val   (load_val),
            .out        (out_v[g]),
            .tc         (tc_v[g]),
            .at_zero    (az_v[g]),
            .at_max     (am_v[g])
`ifdef PARAM_STEP_COUNTER_OVF_STICKY_EN
            ,
            .ovf_sticky (ovf_v[g])
`endif
        );
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Reference: wrap is modular arithmetic over MAX_VAL+1 values, saturate is a clamp.
    task automatic drive(input logic r, c, l, e, u, input logic [5:0] lv);
        exp_t x;
        rstn = r; clr = c; load = l; enable = e; up_dn = u; load_val = lv;
        x = '0;
        for (int i = 0; i < N; i++) begin
            if (r || c) begin
                mo[i] = 0; mp[i] = 0; mv[i] = 0;
            end else if (l) begin
                mo[i] = (int'(lv) > CM[i]) ? CM[i] : int'(lv);
                mp[i] = 0;
            end else if (e) begin
                mp[i] = (mp[i] + 1) % CP[i];
                if (mp[i] == 0) begin
                    if (u ? (mo[i] == CM[i]) : (mo[i] == 0)) begin
                        x.t[i] = 1'b1;
                        mv[i] = 1;
                    end
                    if (CS[i] != 0) mo[i] = u ? ((mo[i] < CM[i]) ? mo[i] + 1 : CM[i]) : ((mo[i] > 0) ? mo[i] - 1 : 0);
                    else mo[i] = u ? (mo[i] + 1) % (CM[i] + 1) : (mo[i] + CM[i]) % (CM[i] + 1);
                end
            end
            x.o[i] = 6'(mo[i]);
            x.v[i] = (mv[i] != 0);
        end
        q.push_back(x);
        @(negedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t x;
        logic [N-1:0] ez, em;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                for (int i = 0; i < N; i++) begin
                    ez[i] = (x.o[i] == 6'd0);
                    em[i] = (int'(x.o[i]) == CM[i]);
                end
                check("out", 32'(out_v), 32'(x.o));
                check("tc", 32'(tc_v), 32'(x.t));
                check("at_zero", 32'(az_v), 32'(ez));
                check("at_max", 32'(am_v), 32'(em));
`ifdef PARAM_STEP_COUNTER_OVF_STICKY_EN
                check("ovf_sticky", 32'(ovf_v), 32'(x.v));
`endif
            end
        end
    end

    initial begin : stim
        logic [N-1:0][5:0] e5;
        logic u;
        rstn = 1'b1; clr = 1'b0; load = 1'b0; enable = 1'b0; up_dn = 1'b1; load_val = '0;
        @(negedge clk);
        #1;
        drive(1, 0, 0, 0, 1, 0);
        drive(1, 0, 1, 1, 1, 6'd7);
        for (int k = 0; k < 66; k++) drive(0, 0, 0, 1, 1, 0);
        drive(0, 0, 1, 0, 0, 6'd3);
        for (int k = 0; k < 5; k++) drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 1, 6'd8);
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 1, 1, 0);
        drive(0, 1, 0, 0, 1, 0);
        for (int k = 0; k < 13; k++) drive(0, 0, 0, (k != 5), 1, 0);
        drive(0, 1, 1, 1, 1, 6'd40);
        drive(0, 0, 1, 0, 1, 6'd63);
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 1, 1, 0);
        drive(0, 0, 1, 0, 1, 6'd20);
        drive(0, 1, 0, 1, 1, 0);
        u = 1'b1;
        for (int k = 0; k < 700; k++) begin
            if ($urandom_range(19) == 0) u = ~u;
            drive(0, $urandom_range(59) == 0, $urandom_range(24) == 0, $urandom_range(4) != 0, u, 6'($urandom));
        end
        // asynchronous reset mid-cycle with a loaded count of 5
        rstn = 1'b0; clr = 1'b0; load = 1'b1; enable = 1'b0; load_val = 6'd5;
        @(posedge clk);
        #2;
        for (int i = 0; i < N; i++) e5[i] = 6'd5;
        check("load5", 32'(out_v), 32'(e5));
        rstn = 1'b1;
        #1;
        check("async_out", 32'(out_v), 32'd0);
        check("async_tc", 32'(tc_v), 32'd0);
        load = 1'b0;
        @(negedge clk);
        #1;
        drive(1, 0, 0, 1, 1, 0);
        for (int k = 0; k < 70; k++) drive(0, 0, 0, 1, 1, 0);
        drive(0, 0, 1, 1, 0, 6'd2);
        for (int k = 0; k < 4; k++) drive(0, 0, 0, 1, 0, 0);
        drive(0, 1, 0, 1, 1, 0);
        for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
        check("drain", q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
